// File: rtl/pattern_generator.sv
// Pattern source for the pattern/score path: picks a fresh pattern from a
// free-running LFSR, shows it for a shrinking hold time or until the player
// matches it, optionally blanks the bus between patterns, and ends the game
// after a fixed number of rounds.
module pattern_generator #(
   parameter logic [15:0] SEED      = 16'hACE1,
   parameter logic [7:0]  HOLD_INIT = 8'd20,
   parameter logic [7:0]  MIN_HOLD  = 8'd5,
   parameter logic [7:0]  GAP_TICKS = 8'd2,
   parameter logic [7:0]  ROUNDS    = 8'd32
) (
   input  logic       counter10h,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] user_input,
   output logic [7:0] pattern,
   output logic [7:0] round,
   output logic       new_pattern,
   output logic       game_over
);

   typedef enum logic [1:0] {StIdle, StShow, StGap, StDone} state_t;

   state_t      state_q, state_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic [7:0]  hold_q, hold_d;
   logic [7:0]  prev_q, prev_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  pattern_q, pattern_d;
   logic [7:0]  round_q, round_d;
   logic        newPattern_q, newPattern_d;
   logic        gameOver_q, gameOver_d;

   logic [7:0]  cand;
   logic [7:0]  loadRound;
   logic [7:0]  holdBase;
   logic [7:0]  holdDecayed;
   logic        showExit;
   logic        gapExit;
   logic        lastRound;
   logic        load;

   // Candidate pattern: low LFSR byte, then high byte, then a fixed fallback,
   // so the result is never blank and never a repeat of the last pattern.
   always_comb begin
      if ((lfsr_q[7:0] != 8'h00) && (lfsr_q[7:0] != prev_q)) begin
         cand = lfsr_q[7:0];
      end else if ((lfsr_q[15:8] != 8'h00) && (lfsr_q[15:8] != prev_q)) begin
         cand = lfsr_q[15:8];
      end else begin
         cand = (prev_q == 8'h01) ? 8'h02 : 8'h01;
      end
   end

   assign showExit    = (user_input == pattern_q) || (cnt_q == hold_q - 8'd1);
   assign gapExit     = (cnt_q == GAP_TICKS - 8'd1);
   assign lastRound   = (round_q == ROUNDS);
   assign loadRound   = (state_q == StIdle) ? 8'd1 : round_q + 8'd1;
   assign holdBase    = (state_q == StIdle) ? HOLD_INIT : hold_q;
   assign holdDecayed = (holdBase > MIN_HOLD) ? holdBase - 8'd1 : MIN_HOLD;
   assign lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

   // State register plus all registered outputs and datapath state.
   always_ff @(posedge counter10h) begin
      if (reset) begin
         state_q      <= StIdle;
         lfsr_q       <= SEED;
         hold_q       <= HOLD_INIT;
         prev_q       <= 8'h00;
         cnt_q        <= 8'h00;
         pattern_q    <= 8'h00;
         round_q      <= 8'h00;
         newPattern_q <= 1'b0;
         gameOver_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         lfsr_q       <= lfsr_d;
         hold_q       <= hold_d;
         prev_q       <= prev_d;
         cnt_q        <= cnt_d;
         pattern_q    <= pattern_d;
         round_q      <= round_d;
         newPattern_q <= newPattern_d;
         gameOver_q   <= gameOver_d;
      end
   end

   // Next-state logic: match and timeout share one exit out of SHOW.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: if (start) state_d = StShow;
         StShow: begin
            if (showExit) begin
               if (lastRound)              state_d = StDone;
               else if (GAP_TICKS == 8'd0) state_d = StShow;
               else                        state_d = StGap;
            end
         end
         StGap:  if (gapExit) state_d = StShow;
         StDone: if (!start) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Output and datapath next values; a load presents a new pattern, bumps
   // the round and shortens the hold every eighth round down to the floor.
   always_comb begin
      pattern_d    = pattern_q;
      round_d      = round_q;
      newPattern_d = 1'b0;
      gameOver_d   = gameOver_q;
      hold_d       = hold_q;
      prev_d       = prev_q;
      cnt_d        = cnt_q;
      load         = 1'b0;
      case (state_q)
         StIdle: begin
            pattern_d = 8'h00;
            if (start) load = 1'b1;
         end
         StShow: begin
            if (showExit) begin
               if (lastRound) begin
                  pattern_d  = 8'h00;
                  gameOver_d = 1'b1;
               end else if (GAP_TICKS == 8'd0) begin
                  load = 1'b1;
               end else begin
                  pattern_d = 8'h00;
                  cnt_d     = 8'h00;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StGap: begin
            if (gapExit) load = 1'b1;
            else         cnt_d = cnt_q + 8'd1;
         end
         StDone: begin
            pattern_d  = 8'h00;
            gameOver_d = 1'b1;
            if (!start) begin
               gameOver_d = 1'b0;
               round_d    = 8'h00;
            end
         end
         default: pattern_d = 8'h00;
      endcase
      if (load) begin
         pattern_d    = cand;
         prev_d       = cand;
         cnt_d        = 8'h00;
         newPattern_d = 1'b1;
         round_d      = loadRound;
         hold_d       = ((loadRound[2:0] == 3'b001) && (loadRound != 8'd1)) ? holdDecayed : holdBase;
      end
   end

   assign pattern     = pattern_q;
   assign round       = round_q;
   assign new_pattern = newPattern_q;
   assign game_over   = gameOver_q;

endmodule

// File: tb/tb_pattern_generator.sv
// Directed bench for pattern_generator: two instances, one with a short hold,
// a gap and three rounds, one with hold decay, no gap and forty rounds.
module tb_pattern_generator;

   logic       clock;
   logic       resetA, startA, resetB, startB;
   logic [7:0] userA, userB;
   logic [7:0] patternA, roundA, patternB, roundB;
   logic       newA, overA, newB, overB;

   logic [15:0] lfsrA, lfsrB, preA, preB;
   logic [7:0]  prevA, prevB, expA, expB;
   logic [15:0] n;
   int          vectorCount = 0;
   int          missCount = 0;

   pattern_generator #(.SEED(16'hACE1), .HOLD_INIT(8'd5), .MIN_HOLD(8'd1),
                       .GAP_TICKS(8'd2), .ROUNDS(8'd3)) dutA (
      .counter10h(clock), .reset(resetA), .start(startA), .user_input(userA),
      .pattern(patternA), .round(roundA), .new_pattern(newA), .game_over(overA));

   pattern_generator #(.SEED(16'hACE1), .HOLD_INIT(8'd6), .MIN_HOLD(8'd4),
                       .GAP_TICKS(8'd0), .ROUNDS(8'd40)) dutB (
      .counter10h(clock), .reset(resetB), .start(startB), .user_input(userB),
      .pattern(patternB), .round(roundB), .new_pattern(newB), .game_over(overB));

   // Free-running game tick.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [15:0] lfsrStep(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   function automatic logic [7:0] pickPattern(input logic [15:0] v, input logic [7:0] prev);
      logic [7:0] lo, hi;
      lo = v[7:0];
      hi = v[15:8];
      if (lo != 8'h00 && lo != prev) return lo;
      if (hi != 8'h00 && hi != prev) return hi;
      return (prev == 8'h01) ? 8'h02 : 8'h01;
   endfunction

   function automatic logic [15:0] expHold(input int r);
      if (r <= 8)  return 16'd6;
      if (r <= 16) return 16'd5;
      return 16'd4;
   endfunction

   // Reference LFSRs that advance on every edge exactly like the design's.
   always @(posedge clock) begin
      lfsrA <= resetA ? 16'hACE1 : lfsrStep(lfsrA);
      lfsrB <= resetB ? 16'hACE1 : lfsrStep(lfsrB);
   end

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulusA(input logic rst, input logic st, input logic [7:0] usr);
      resetA = rst;
      startA = st;
      userA  = usr;
      preA   = lfsrA;
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulusB(input logic rst, input logic st, input logic [7:0] usr);
      resetB = rst;
      startB = st;
      userB  = usr;
      preB   = lfsrB;
      @(posedge clock);
      #1;
   endtask

   initial begin
      resetA = 1'b1; startA = 1'b0; userA = 8'h00;
      resetB = 1'b1; startB = 1'b0; userB = 8'h00;
      prevA = 8'h00; prevB = 8'h00;

      // Reset values and the very first pattern.
      applyStimulusA(1'b1, 1'b0, 8'h00);
      checkOutput("A reset pattern", {8'h00, patternA}, 16'h0000);
      checkOutput("A reset round", {8'h00, roundA}, 16'h0000);
      checkOutput("A reset new", {15'd0, newA}, 16'd0);
      checkOutput("A reset over", {15'd0, overA}, 16'd0);
      applyStimulusA(1'b0, 1'b1, 8'h00);
      checkOutput("A first pattern", {8'h00, patternA}, 16'h00E1);
      checkOutput("A first round", {8'h00, roundA}, 16'd1);
      checkOutput("A first new", {15'd0, newA}, 16'd1);
      prevA = 8'hE1;

      // Hold of five ticks, then two blank gap ticks, then round 2.
      for (int t = 1; t <= 4; t++) begin
         applyStimulusA(1'b0, 1'b0, 8'h00);
         checkOutput("A hold visible", {8'h00, patternA}, 16'h00E1);
         checkOutput("A new one tick", {15'd0, newA}, 16'd0);
      end
      applyStimulusA(1'b0, 1'b0, 8'h00);
      checkOutput("A hold end", {8'h00, patternA}, 16'h0000);
      applyStimulusA(1'b0, 1'b0, 8'h00);
      checkOutput("A gap blank", {8'h00, patternA}, 16'h0000);
      applyStimulusA(1'b0, 1'b0, 8'h00);
      expA = pickPattern(preA, prevA);
      checkOutput("A round2 pattern", {8'h00, patternA}, {8'h00, expA});
      checkOutput("A round2 round", {8'h00, roundA}, 16'd2);
      checkOutput("A round2 new", {15'd0, newA}, 16'd1);
      checkOutput("A round2 differs", {15'd0, (patternA != prevA) && (patternA != 8'h00)}, 16'd1);
      prevA = expA;

      // Early match on the second SHOW tick, input left asserted through the gap.
      applyStimulusA(1'b0, 1'b0, 8'h00);
      checkOutput("A pre-match visible", {8'h00, patternA}, {8'h00, expA});
      applyStimulusA(1'b0, 1'b0, expA);
      checkOutput("A match clears", {8'h00, patternA}, 16'h0000);
      checkOutput("A match round", {8'h00, roundA}, 16'd2);
      applyStimulusA(1'b0, 1'b0, expA);
      checkOutput("A match gap", {8'h00, patternA}, 16'h0000);
      applyStimulusA(1'b0, 1'b0, expA);
      expA = pickPattern(preA, prevA);
      checkOutput("A round3 pattern", {8'h00, patternA}, {8'h00, expA});
      checkOutput("A round3 round", {8'h00, roundA}, 16'd3);
      prevA = expA;

      // Last round times out into DONE; start high holds DONE, low returns to IDLE.
      for (int t = 1; t <= 4; t++) applyStimulusA(1'b0, 1'b0, 8'h00);
      checkOutput("A last visible", {8'h00, patternA}, {8'h00, expA});
      applyStimulusA(1'b0, 1'b0, 8'h00);
      checkOutput("A done over", {15'd0, overA}, 16'd1);
      checkOutput("A done pattern", {8'h00, patternA}, 16'h0000);
      checkOutput("A done round", {8'h00, roundA}, 16'd3);
      for (int t = 1; t <= 2; t++) begin
         applyStimulusA(1'b0, 1'b1, 8'h00);
         checkOutput("A done held", {15'd0, overA}, 16'd1);
         checkOutput("A done round held", {8'h00, roundA}, 16'd3);
      end
      applyStimulusA(1'b0, 1'b0, 8'h00);
      checkOutput("A idle over", {15'd0, overA}, 16'd0);
      checkOutput("A idle round", {8'h00, roundA}, 16'd0);

      // Restart, then reset in the middle of SHOW.
      applyStimulusA(1'b0, 1'b1, 8'h00);
      expA = pickPattern(preA, prevA);
      checkOutput("A restart pattern", {8'h00, patternA}, {8'h00, expA});
      checkOutput("A restart round", {8'h00, roundA}, 16'd1);
      prevA = expA;
      applyStimulusA(1'b0, 1'b0, 8'h00);
      applyStimulusA(1'b0, 1'b0, 8'h00);
      applyStimulusA(1'b1, 1'b0, 8'h00);
      checkOutput("A midreset pattern", {8'h00, patternA}, 16'h0000);
      checkOutput("A midreset round", {8'h00, roundA}, 16'd0);
      checkOutput("A midreset over", {15'd0, overA}, 16'd0);
      checkOutput("A midreset new", {15'd0, newA}, 16'd0);
      applyStimulusA(1'b0, 1'b0, 8'h00);

      // Hold decay over a full forty-round game with no gap.
      applyStimulusB(1'b1, 1'b0, 8'h00);
      applyStimulusB(1'b0, 1'b1, 8'h00);
      checkOutput("B first pattern", {8'h00, patternB}, 16'h00E1);
      prevB = 8'hE1;
      for (int r = 1; r <= 40; r++) begin
         n = 16'd0;
         do begin
            applyStimulusB(1'b0, 1'b0, 8'h00);
            n++;
         end while (!newB && !overB && n < 16'd20);
         checkOutput($sformatf("B hold round %0d", r), n, expHold(r));
         if (r < 40) begin
            expB = pickPattern(preB, prevB);
            checkOutput("B load pattern", {8'h00, patternB}, {8'h00, expB});
            checkOutput("B load round", {8'h00, roundB}, 16'(r + 1));
            prevB = expB;
         end else begin
            checkOutput("B end over", {15'd0, overB}, 16'd1);
            checkOutput("B end round", {8'h00, roundB}, 16'd40);
            checkOutput("B end pattern", {8'h00, patternB}, 16'h0000);
         end
      end

      // Soak with random button activity; every load must follow the LFSR model.
      applyStimulusB(1'b0, 1'b0, 8'h00);
      checkOutput("B idle round", {8'h00, roundB}, 16'd0);
      applyStimulusB(1'b0, 1'b1, 8'h00);
      expB = pickPattern(preB, prevB);
      checkOutput("B soak first", {8'h00, patternB}, {8'h00, expB});
      prevB = expB;
      for (int k = 0; k < 3000 && !overB; k++) begin
         applyStimulusB(1'b0, 1'b0, ($urandom_range(3) == 0) ? prevB : 8'($urandom));
         if (newB) begin
            expB = pickPattern(preB, prevB);
            checkOutput("B soak pattern", {8'h00, patternB}, {8'h00, expB});
            checkOutput("B soak nonzero", {15'd0, patternB != 8'h00}, 16'd1);
            checkOutput("B soak no repeat", {15'd0, patternB != prevB}, 16'd1);
            prevB = expB;
         end
      end
      checkOutput("B soak over", {15'd0, overB}, 16'd1);
      checkOutput("B soak round", {8'h00, roundB}, 16'd40);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
